// File: rtl/nnrv_mem_arb_if.sv
// nnrv memory arbiter bus bundle: fetch, load/store and RAM ports.
// slave is the arbiter's view, master is the core/RAM side.
interface nnrv_mem_arb_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int XLEN       = 32
);
  logic                  i_if_req;
  logic [ADDR_WIDTH-1:0] i_if_addr;
  logic                  o_if_gnt;
  logic                  o_if_rvalid;
  logic [XLEN-1:0]       o_if_rdata;

  logic                  i_ls_req;
  logic                  i_ls_we;
  logic [ADDR_WIDTH-1:0] i_ls_addr;
  logic [3:0]            i_ls_mask;
  logic [XLEN-1:0]       i_ls_wdata;
  logic                  o_ls_gnt;
  logic                  o_ls_rvalid;
  logic [XLEN-1:0]       o_ls_rdata;

  logic [ADDR_WIDTH-1:0] o_ram_rd_addr;
  logic                  o_ram_rd_en;
  logic [3:0]            o_ram_rd_mask;
  logic [XLEN-1:0]       i_ram_rd_data;
  logic [ADDR_WIDTH-1:0] o_ram_wr_addr;
  logic                  o_ram_wr_en;
  logic [3:0]            o_ram_wr_mask;
  logic [XLEN-1:0]       o_ram_wr_data;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_ls_req, i_ls_we, i_ls_addr,
    input  i_ls_mask, i_ls_wdata,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_ram_rd_addr, o_ram_rd_en,
    output o_ram_rd_mask,
    input  i_ram_rd_data,
    output o_ram_wr_addr, o_ram_wr_en,
    output o_ram_wr_mask, o_ram_wr_data
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_ls_req, i_ls_we, i_ls_addr,
    output i_ls_mask, i_ls_wdata,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_ram_rd_addr, o_ram_rd_en,
    input  o_ram_rd_mask,
    output i_ram_rd_data,
    input  o_ram_wr_addr, o_ram_wr_en,
    input  o_ram_wr_mask, o_ram_wr_data
  );
endinterface

// File: rtl/nnrv_mem_arb.sv
// nnrv memory arbiter: shares one RAM read port between fetch and loads,
// stores go straight to the write port; fetch has bounded starvation.
module nnrv_mem_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  nnrv_mem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_LS = 2'd2
  } own_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  own_e state_q;
  own_e state_d;

  logic [3:0]            starve_cnt;
  logic                  st_req;
  logic                  ld_req;
  logic                  force_if;
  logic                  if_gnt;
  logic                  ld_gnt;
  logic                  st_gnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [3:0]            rd_mask;
  logic [XLEN-1:0]       rd_data;

  always_comb begin
    st_req   = bus.i_ls_req & bus.i_ls_we;
    ld_req   = bus.i_ls_req & ~bus.i_ls_we;
    force_if = (starve_cnt == SMAX);
  end

  // Read grant: load wins contention until fetch has waited SMAX cycles.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    st_gnt = 1'b0;
    if (!i_rst) begin
      st_gnt = st_req;
      unique case (1'b1)
        (bus.i_if_req & (~ld_req | force_if)):
          if_gnt = 1'b1;
        (ld_req & (~bus.i_if_req | ~force_if)):
          ld_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (bus.i_if_req & ~if_gnt) begin
      if (starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      if_gnt:  state_d = OWN_IF;
      ld_gnt:  state_d = OWN_LS;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_if_rvalid = (state_q == OWN_IF);
    bus.o_ls_rvalid = (state_q == OWN_LS);
  end

  always_comb begin
    rd_addr = '0;
    rd_mask = 4'b0000;
    unique case (1'b1)
      if_gnt: begin
        rd_addr = bus.i_if_addr;
        rd_mask = 4'b1111;
      end
      ld_gnt: begin
        rd_addr = bus.i_ls_addr;
        rd_mask = bus.i_ls_mask;
      end
      default: ;
    endcase
  end

  // No store-to-read forwarding: a same-cycle read sees the old word.
  always_comb begin
    rd_data           = bus.i_ram_rd_data;
    bus.o_if_gnt      = if_gnt;
    bus.o_ls_gnt      = ld_gnt | st_gnt;
    bus.o_if_rdata    = rd_data;
    bus.o_ls_rdata    = rd_data;
    bus.o_ram_rd_en   = if_gnt | ld_gnt;
    bus.o_ram_rd_addr = rd_addr;
    bus.o_ram_rd_mask = rd_mask;
    bus.o_ram_wr_en   = st_gnt;
    bus.o_ram_wr_addr = bus.i_ls_addr;
    bus.o_ram_wr_mask = bus.i_ls_mask;
    bus.o_ram_wr_data = bus.i_ls_wdata;
  end

endmodule

// File: tb/tb_nnrv_mem_arb.sv
// Bench for nnrv_mem_arb: directed scenarios plus randomized traffic
// against a grant/starvation/memory reference model.
module tb_nnrv_mem_arb;
  localparam int AW   = 8;
  localparam int XL   = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_ram = 1'b1;
  always #5 clk = ~clk;

  nnrv_mem_arb_if #(.ADDR_WIDTH(AW), .XLEN(XL)) bus ();

  nnrv_mem_arb #(
    .ADDR_WIDTH(AW),
    .XLEN(XL),
    .STARVE_MAX(SMAX)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'(i);
    end else begin
      if (bus.o_ram_rd_en)
        bus.i_ram_rd_data <= ram[bus.o_ram_rd_addr[7:2]];
      if (bus.o_ram_wr_en)
        for (int b = 0; b < 4; b++)
          if (bus.o_ram_wr_mask[b])
            ram[bus.o_ram_wr_addr[7:2]][8*b +: 8] <= bus.o_ram_wr_data[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_err = 0;
  int denials = 0;

  logic e_if_gnt, e_ls_gnt, e_rd_en, e_wr_en, e_if_rv, e_ls_rv;
  logic [7:0] e_rd_addr;
  logic [3:0] e_rd_mask;
  logic [31:0] e_rdata;
  logic o_if_gnt, o_ls_gnt, o_rd_en, o_wr_en, o_if_rv, o_ls_rv;
  logic [7:0] o_rd_addr, o_wr_addr;
  logic [3:0] o_rd_mask, o_wr_mask;
  logic [31:0] o_wr_data, o_if_rdata, o_ls_rdata;

  // One clock of traffic: predicts, samples grants mid-cycle and
  // responses just after the edge. Called at posedge+1.
  task automatic cycle(input logic ifr, input logic [7:0] ifa,
                       input logic lsr, input logic we,
                       input logic [7:0] lsa, input logic [3:0] m,
                       input logic [31:0] wd);
    logic ld;
    bus.i_if_req = ifr; bus.i_if_addr = ifa;
    bus.i_ls_req = lsr; bus.i_ls_we = we; bus.i_ls_addr = lsa;
    bus.i_ls_mask = m; bus.i_ls_wdata = wd;
    ld = lsr & ~we;
    e_wr_en = lsr & we;
    if (ifr && ld) begin
      e_if_gnt = (denials >= SMAX);
      e_ls_gnt = ~e_if_gnt;
    end else begin
      e_if_gnt = ifr;
      e_ls_gnt = lsr;
    end
    e_rd_en = e_if_gnt | (e_ls_gnt & ld);
    e_rd_addr = e_if_gnt ? ifa : (e_ls_gnt && ld) ? lsa : 8'h00;
    e_rd_mask = e_if_gnt ? 4'hf : (e_ls_gnt && ld) ? m : 4'h0;
    denials = (ifr && !e_if_gnt) ? denials + 1 : 0;
    @(negedge clk);
    o_if_gnt = bus.o_if_gnt; o_ls_gnt = bus.o_ls_gnt;
    o_rd_en = bus.o_ram_rd_en; o_rd_addr = bus.o_ram_rd_addr;
    o_rd_mask = bus.o_ram_rd_mask; o_wr_en = bus.o_ram_wr_en;
    o_wr_addr = bus.o_ram_wr_addr; o_wr_mask = bus.o_ram_wr_mask;
    o_wr_data = bus.o_ram_wr_data;
    e_if_rv = e_if_gnt;
    e_ls_rv = e_ls_gnt & ld;
    e_rdata = ref_mem[e_rd_addr[7:2]];
    if (e_wr_en)
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[lsa[7:2]][8*b +: 8] = wd[8*b +: 8];
    @(posedge clk);
    #1;
    o_if_rv = bus.o_if_rvalid; o_ls_rv = bus.o_ls_rvalid;
    o_if_rdata = bus.o_if_rdata; o_ls_rdata = bus.o_ls_rdata;
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    bus.i_if_req = 1'b1; bus.i_if_addr = 8'h04;
    bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b1; bus.i_ls_addr = 8'h08;
    bus.i_ls_mask = 4'hf; bus.i_ls_wdata = 32'hffff_ffff;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_if_gnt, bus.o_ls_gnt, bus.o_ram_rd_en, bus.o_ram_wr_en} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_gnt: got %b expected 0000",
        {bus.o_if_gnt, bus.o_ls_gnt, bus.o_ram_rd_en, bus.o_ram_wr_en});
    end
    n_checks++;
    if ({bus.o_if_rvalid, bus.o_ls_rvalid} !== 2'b00 || dut.starve_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: rvalid %b starve %0d expected 00 0",
        {bus.o_if_rvalid, bus.o_ls_rvalid}, dut.starve_cnt);
    end
    bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0;
    init_ram = 1'b0;
    rst = 1'b0;
    denials = 0;
    idle();
    n_checks++;
    if ({o_if_rv, o_ls_rv} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release_rvalid: got %b expected 00", {o_if_rv, o_ls_rv});
    end
  endtask

  task automatic test_if_stream();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'(4 * k), 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
      n_checks++;
      if (o_if_gnt !== 1'b1 || o_if_rv !== 1'b1 || o_ls_rv !== 1'b0) begin
        n_err++;
        $display("FAIL if_stream_%0d: gnt %b rv %b lsrv %b expected 1 1 0",
          k, o_if_gnt, o_if_rv, o_ls_rv);
      end
      n_checks++;
      if (o_if_rdata !== 32'(k)) begin
        n_err++;
        $display("FAIL if_stream_data_%0d: got %h expected %h", k, o_if_rdata, 32'(k));
      end
    end
    idle();
    n_checks++;
    if (o_if_rv !== 1'b0) begin
      n_err++;
      $display("FAIL if_stream_end: rvalid %b expected 0", o_if_rv);
    end
  endtask

  task automatic test_starvation();
    logic want_if;
    for (int k = 0; k < 10; k++) begin
      want_if = ((k % 5) == 4);
      cycle(1'b1, 8'h04, 1'b1, 1'b0, 8'h08, 4'h3, 32'h0);
      n_checks++;
      if (o_if_gnt !== want_if || o_ls_gnt !== ~want_if) begin
        n_err++;
        $display("FAIL starve_pattern_%0d: if %b ls %b expected %b %b",
          k, o_if_gnt, o_ls_gnt, want_if, ~want_if);
      end
      n_checks++;
      if (o_if_rv !== want_if || o_ls_rv !== ~want_if ||
          o_ls_rdata !== (want_if ? 32'd1 : 32'd2)) begin
        n_err++;
        $display("FAIL starve_resp_%0d: ifrv %b lsrv %b data %h",
          k, o_if_rv, o_ls_rv, o_ls_rdata);
      end
      n_checks++;
      if (dut.starve_cnt > 4'(SMAX)) begin
        n_err++;
        $display("FAIL starve_cnt_%0d: got %0d expected <= %0d", k, dut.starve_cnt, SMAX);
      end
    end
    idle();
  endtask

  task automatic test_store_if();
    cycle(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 4'hf, 32'hdead_beef);
    n_checks++;
    if ({o_if_gnt, o_ls_gnt, o_wr_en} !== 3'b111 || o_wr_addr !== 8'h20 ||
        o_wr_data !== 32'hdead_beef) begin
      n_err++;
      $display("FAIL store_if_gnt: gnt/wr %b addr %h data %h expected 111 20 deadbeef",
        {o_if_gnt, o_ls_gnt, o_wr_en}, o_wr_addr, o_wr_data);
    end
    n_checks++;
    if (o_if_rv !== 1'b1 || o_if_rdata !== 32'd4 || o_ls_rv !== 1'b0) begin
      n_err++;
      $display("FAIL store_if_resp: rv %b data %h lsrv %b expected 1 4 0",
        o_if_rv, o_if_rdata, o_ls_rv);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 4'hf, 32'h0);
    n_checks++;
    if (o_ls_rv !== 1'b1 || o_ls_rdata !== 32'hdead_beef) begin
      n_err++;
      $display("FAIL store_readback: rv %b data %h expected 1 deadbeef", o_ls_rv, o_ls_rdata);
    end
  endtask

  task automatic test_no_forward();
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 4'hf, 32'h1111_1111);
    cycle(1'b1, 8'h30, 1'b1, 1'b1, 8'h30, 4'hf, 32'h2222_2222);
    n_checks++;
    if (o_if_rv !== 1'b1 || o_if_rdata !== 32'h1111_1111) begin
      n_err++;
      $display("FAIL no_fwd_if: rv %b data %h expected 1 11111111", o_if_rv, o_if_rdata);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 4'hf, 32'h1111_1111);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 4'hf, 32'h0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 4'hf, 32'h3333_3333);
    n_checks++;
    if (o_ls_rv !== 1'b0) begin
      n_err++;
      $display("FAIL load_store_rv2: rv %b expected 0", o_ls_rv);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 4'hf, 32'h0);
    n_checks++;
    if (o_ls_rv !== 1'b1 || o_ls_rdata !== 32'h3333_3333) begin
      n_err++;
      $display("FAIL load_after_store: rv %b data %h expected 1 33333333", o_ls_rv, o_ls_rdata);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 8'h04, 1'b1, 1'b0, 8'h08, 4'hf, 32'h0);
    cycle(1'b1, 8'h04, 1'b1, 1'b0, 8'h08, 4'hf, 32'h0);
    bus.i_if_req = 1'b1; bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_ls_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre_gnt: got %b expected 1", bus.o_ls_gnt);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_if_gnt, bus.o_ls_gnt, bus.o_ram_rd_en} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_mid_gnt: got %b expected 000",
        {bus.o_if_gnt, bus.o_ls_gnt, bus.o_ram_rd_en});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_if_rvalid, bus.o_ls_rvalid} !== 2'b00 || dut.starve_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL rst_mid_state: rvalid %b starve %0d expected 00 0",
        {bus.o_if_rvalid, bus.o_ls_rvalid}, dut.starve_cnt);
    end
    bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0;
    rst = 1'b0;
    denials = 0;
    idle();
    n_checks++;
    if ({o_if_rv, o_ls_rv} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_after: rvalid %b expected 00", {o_if_rv, o_ls_rv});
    end
  endtask

  task automatic test_random();
    logic p_if, p_ls, p_we;
    logic [7:0] p_ifa, p_lsa;
    logic [3:0] p_m;
    logic [31:0] p_wd;
    p_if = 1'b0; p_ls = 1'b0;
    p_we = 1'b0; p_ifa = 8'h0; p_lsa = 8'h0; p_m = 4'h0; p_wd = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!p_if) begin
        p_if = 1'($urandom_range(0, 1));
        p_ifa = 8'($urandom_range(0, 63) << 2);
      end
      if (!p_ls) begin
        p_ls = 1'($urandom_range(0, 1));
        p_we = 1'($urandom_range(0, 2) == 0);
        p_lsa = 8'($urandom_range(0, 63) << 2);
        p_m = 4'($urandom_range(1, 15));
        p_wd = $urandom;
      end
      cycle(p_if, p_ifa, p_ls, p_we, p_lsa, p_m, p_wd);
      n_checks++;
      if ({o_if_gnt, o_ls_gnt, o_rd_en, o_wr_en, o_rd_addr, o_rd_mask} !==
          {e_if_gnt, e_ls_gnt, e_rd_en, e_wr_en, e_rd_addr, e_rd_mask}) begin
        n_err++;
        $display("FAIL rand_gnt_%0d: got %b %b %b %b %h %h expected %b %b %b %b %h %h", n,
          o_if_gnt, o_ls_gnt, o_rd_en, o_wr_en, o_rd_addr, o_rd_mask,
          e_if_gnt, e_ls_gnt, e_rd_en, e_wr_en, e_rd_addr, e_rd_mask);
      end
      n_checks++;
      if (e_wr_en && {o_wr_addr, o_wr_mask, o_wr_data} !== {p_lsa, p_m, p_wd}) begin
        n_err++;
        $display("FAIL rand_wr_%0d: got %h %h %h expected %h %h %h", n,
          o_wr_addr, o_wr_mask, o_wr_data, p_lsa, p_m, p_wd);
      end
      n_checks++;
      if ({o_if_rv, o_ls_rv} !== {e_if_rv, e_ls_rv}) begin
        n_err++;
        $display("FAIL rand_rv_%0d: got %b%b expected %b%b", n,
          o_if_rv, o_ls_rv, e_if_rv, e_ls_rv);
      end
      n_checks++;
      if ((e_if_rv && o_if_rdata !== e_rdata) || (e_ls_rv && o_ls_rdata !== e_rdata)) begin
        n_err++;
        $display("FAIL rand_data_%0d: got %h/%h expected %h", n,
          o_if_rdata, o_ls_rdata, e_rdata);
      end
      if (e_if_gnt) p_if = 1'b0;
      if (e_ls_gnt) p_ls = 1'b0;
    end
  endtask

  initial begin
    bus.i_if_req = 1'b0; bus.i_if_addr = 8'h0;
    bus.i_ls_req = 1'b0; bus.i_ls_we = 1'b0; bus.i_ls_addr = 8'h0;
    bus.i_ls_mask = 4'h0; bus.i_ls_wdata = 32'h0;
    test_reset();
    test_if_stream();
    test_starvation();
    test_store_if();
    test_no_forward();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
